// File: rtl/nand_deglitch_pkg.sv
// Shared types and constants for the NAND deglitch filter.
//   state_t      : per-channel filter state (STABLE / SETTLING)
//   GLITCH_CNT_W : width of each per-channel rejected-glitch counter
package nand_deglitch_pkg;

  localparam int unsigned GLITCH_CNT_W = 8;

  typedef enum logic {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } state_t;

endpackage

// File: rtl/nand_deglitch_ch.sv
// One deglitched NAND channel: combinational NAND, 2-flop synchronizer,
// then a settle filter that only lets a new value through after it has
// persisted for STABLE_CYCLES consecutive cycles.
// Optional feature macro: NAND_DEGLITCH_GLITCH_CNT_EN (adds glitch_cnt).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in         : WIDTH asynchronous gate inputs
//   out        : filtered NAND result (resets to 1)
//   chg        : one-cycle pulse in the cycle following an out change
//   glitch_cnt : saturating count of rejected glitches (macro only)
module nand_deglitch_ch
  import nand_deglitch_pkg::*;
#(
  parameter int unsigned WIDTH         = 2,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic             out,
  output logic             chg
`ifdef NAND_DEGLITCH_GLITCH_CNT_EN
  ,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

  logic             raw;
  logic             s1;
  logic             s2;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  assign raw = ~(&in);

  // Synchronizer, settle filter and change pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      state <= STABLE;
      cnt   <= '0;
      out   <= 1'b1;
      chg   <= 1'b0;
`ifdef NAND_DEGLITCH_GLITCH_CNT_EN
      glitch_cnt <= '0;
`endif
    end else begin
      s1  <= raw;
      s2  <= s1;
      chg <= 1'b0;
      case (state)
        STABLE: begin
          if (s2 != out) begin
            // A one-cycle filter accepts the new value on first sight.
            if (STABLE_CYCLES == 1) begin
              out <= s2;
              chg <= 1'b1;
            end else begin
              state <= SETTLING;
              cnt   <= CNT_W'(1);
            end
          end
        end
        SETTLING: begin
          if (s2 != out) begin
            // Counter stops at STABLE_CYCLES-1, so it can never wrap.
            if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
              out   <= s2;
              chg   <= 1'b1;
              cnt   <= '0;
              state <= STABLE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else begin
            cnt   <= '0;
            state <= STABLE;
`ifdef NAND_DEGLITCH_GLITCH_CNT_EN
            if (glitch_cnt != '1) begin
              glitch_cnt <= glitch_cnt + GLITCH_CNT_W'(1);
            end
`endif
          end
        end
        default: begin
          state <= STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/nand_deglitch.sv
// Multi-channel deglitched NAND gate; each channel is an independent
// nand_deglitch_ch instance.
// Optional feature macro: NAND_DEGLITCH_GLITCH_CNT_EN (adds glitch_cnt).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in         : CHANNELS*WIDTH gate inputs, channel c at [c*WIDTH +: WIDTH]
//   out        : filtered NAND result per channel (resets to all ones)
//   chg        : per-channel one-cycle pulse following an out change
//   glitch_cnt : per-channel 8-bit saturating rejected-glitch count (macro only)
module nand_deglitch
  import nand_deglitch_pkg::*;
#(
  parameter int unsigned WIDTH         = 2,
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in,
  output logic [CHANNELS-1:0]       out,
  output logic [CHANNELS-1:0]       chg
`ifdef NAND_DEGLITCH_GLITCH_CNT_EN
  ,
  output logic [CHANNELS*GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

  // One filter per channel; no state is shared between channels.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    nand_deglitch_ch #(
      .WIDTH         (WIDTH),
      .STABLE_CYCLES (STABLE_CYCLES)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .in         (in[c*WIDTH +: WIDTH]),
      .out        (out[c]),
      .chg        (chg[c])
`ifdef NAND_DEGLITCH_GLITCH_CNT_EN
      ,
      .glitch_cnt (glitch_cnt[c*GLITCH_CNT_W +: GLITCH_CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_nand_deglitch.sv
// Directed self-checking bench for nand_deglitch (WIDTH=2, CHANNELS=4,
// STABLE_CYCLES=4). Glitch-counter checks apply when
// NAND_DEGLITCH_GLITCH_CNT_EN is defined.
module tb_nand_deglitch;

  localparam int unsigned WIDTH         = 2;
  localparam int unsigned CHANNELS      = 4;
  localparam int unsigned STABLE_CYCLES = 4;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [CHANNELS*WIDTH-1:0] in;
  logic [CHANNELS-1:0]       out;
  logic [CHANNELS-1:0]       chg;
`ifdef NAND_DEGLITCH_GLITCH_CNT_EN
  logic [CHANNELS*8-1:0]     glitch_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int chg_cnt [CHANNELS] = '{default: 0};
  int out_tog [CHANNELS] = '{default: 0};
  logic [CHANNELS-1:0] out_q;

  int base_chg;
  int base_tog;

  always #5 clk = ~clk;

  nand_deglitch #(
    .WIDTH         (WIDTH),
    .CHANNELS      (CHANNELS),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (in),
    .out        (out),
    .chg        (chg)
`ifdef NAND_DEGLITCH_GLITCH_CNT_EN
    ,
    .glitch_cnt (glitch_cnt)
`endif
  );

  // Tally chg pulses and out transitions per channel, sampled mid-cycle.
  always @(negedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (rst_n === 1'b1) begin
        if (chg[c] === 1'b1) chg_cnt[c]++;
        if (out[c] !== out_q[c]) out_tog[c]++;
      end
    end
    out_q = out;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    in    = 8'hA5;
    #2 rst_n = 1'b0;
    #1;
    // Reset takes effect without a clock edge.
    check("rst_out", 32'(out), 32'hF);
    check("rst_chg", 32'(chg), 32'h0);
`ifdef NAND_DEGLITCH_GLITCH_CNT_EN
    check("rst_gcnt", glitch_cnt, 32'h0);
`endif

    @(negedge clk);
    @(negedge clk);
    in    = 8'h00;
    rst_n = 1'b1;
    cycles(4);
    check("idle_out", 32'(out), 32'hF);
    check("idle_chg", 32'(chg), 32'h0);

    // Ch0 to 11: out falls on the 6th edge, chg one cycle.
    @(negedge clk);
    in[1:0] = 2'b11;
    cycles(5);
    check("lat_out_e5", 32'(out[0]), 32'h1);
    check("lat_chg_e5", 32'(chg[0]), 32'h0);
    cycles(1);
    check("lat_out_e6", 32'(out[0]), 32'h0);
    check("lat_chg_e6", 32'(chg[0]), 32'h1);
    cycles(1);
    check("lat_chg_e7", 32'(chg[0]), 32'h0);
    check("lat_out_e7", 32'(out[0]), 32'h0);

    // Skewed 11 -> 01 -> 00: single rise, single pulse.
    base_chg = chg_cnt[0];
    base_tog = out_tog[0];
    @(negedge clk);
    in[0] = 1'b0;
    #1 in[1] = 1'b0;
    cycles(12);
    check("skew_out", 32'(out[0]), 32'h1);
    check("skew_chg", 32'(chg_cnt[0] - base_chg), 32'd1);
    check("skew_tog", 32'(out_tog[0] - base_tog), 32'd1);
`ifdef NAND_DEGLITCH_GLITCH_CNT_EN
    check("skew_gcnt", 32'(glitch_cnt[7:0]), 32'd0);
`endif

    // Ch1 2-cycle glitch is rejected and counted.
    base_chg = chg_cnt[1];
    @(negedge clk);
    in[3:2] = 2'b11;
    @(negedge clk);
    @(negedge clk);
    in[3:2] = 2'b00;
    cycles(8);
    check("g1_out", 32'(out[1]), 32'h1);
    check("g1_chg", 32'(chg_cnt[1] - base_chg), 32'd0);
`ifdef NAND_DEGLITCH_GLITCH_CNT_EN
    check("g1_gcnt", 32'(glitch_cnt[15:8]), 32'd1);
`endif

    // 300 glitches on ch2: counter saturates, out never moves.
    base_chg = chg_cnt[2];
    base_tog = out_tog[2];
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      in[5:4] = 2'b11;
      @(negedge clk);
      @(negedge clk);
      in[5:4] = 2'b00;
      @(negedge clk);
    end
    cycles(8);
    check("g2_out", 32'(out[2]), 32'h1);
    check("g2_chg", 32'(chg_cnt[2] - base_chg), 32'd0);
    check("g2_tog", 32'(out_tog[2] - base_tog), 32'd0);
`ifdef NAND_DEGLITCH_GLITCH_CNT_EN
    check("g2_gcnt", 32'(glitch_cnt[23:16]), 32'd255);
`endif

    // Drive ch0 low so reset has something visible to undo.
    @(negedge clk);
    in[1:0] = 2'b11;
    cycles(8);
    check("pre_rst_out", 32'(out), 32'hE);

    // Ch3 settling (count=2) interrupted by reset.
    @(negedge clk);
    in[7:6] = 2'b11;
    cycles(4);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out", 32'(out), 32'hF);
    check("mid_rst_chg", 32'(chg), 32'h0);
`ifdef NAND_DEGLITCH_GLITCH_CNT_EN
    check("mid_rst_gcnt", glitch_cnt, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    cycles(5);
    check("post_rst_e5", 32'(out), 32'hF);
    cycles(1);
    check("post_rst_e6", 32'(out), 32'h6);
    check("post_rst_chg", 32'(chg), 32'h9);
    cycles(1);
    check("post_rst_chg_e7", 32'(chg), 32'h0);

    // All channels change together.
    @(negedge clk);
    in = 8'h00;
    cycles(8);
    check("all_idle", 32'(out), 32'hF);
    @(negedge clk);
    in = 8'hFF;
    cycles(5);
    check("all_e5", 32'(out), 32'hF);
    cycles(1);
    check("all_e6_out", 32'(out), 32'h0);
    check("all_e6_chg", 32'(chg), 32'hF);
    cycles(1);
    check("all_e7_chg", 32'(chg), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nand_deglitch.md
NAND_DEGLITCH -- requirements
Module: nand_deglitch

Interface
REQ-001 SHALL provide parameter WIDTH, default 2, inputs per NAND channel (range 2..8).
REQ-002 SHALL provide parameter CHANNELS, default 4, independent NAND channels (range 1..16).
REQ-003 SHALL provide parameter STABLE_CYCLES, default 4, consecutive cycles a new NAND result must persist before the output changes (range 1..255).
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in, input, CHANNELS*WIDTH, asynchronous gate inputs; channel c uses bits [c*WIDTH +: WIDTH].
REQ-007 SHALL have port out, output, CHANNELS, registered, filtered NAND result per channel.
REQ-008 SHALL have port chg, output, CHANNELS, one-cycle pulse per channel when out[c] changes.
REQ-009 SHALL have port glitch_cnt, output, CHANNELS*8, per-channel rejected-glitch count (present only with NAND_DEGLITCH_GLITCH_CNT_EN).

Function
REQ-010 SHALL compute raw[c] = NOT(AND of channel c inputs) combinationally, then pass it through a 2-flop synchronizer (s1, s2).
REQ-011 SHALL run per channel a 2-state FSM: STABLE (s2 == out) and SETTLING (s2 != out).
REQ-012 In STABLE: s2 != out SHALL move to SETTLING with settle count = 1; if STABLE_CYCLES == 1, out SHALL take s2 on that same edge instead.
REQ-013 In SETTLING: s2 != out SHALL increment the count; on the edge where the count would reach STABLE_CYCLES, out SHALL take s2, count SHALL clear, FSM SHALL return to STABLE.
REQ-014 In SETTLING: s2 == out SHALL clear the count, return to STABLE, and count one rejected glitch.
REQ-015 Latency from an input change that settles before edge k SHALL be out updating on edge k+1+STABLE_CYCLES.
REQ-016 chg[c] SHALL be high exactly the cycle after out[c] changes, otherwise low.
REQ-017 The settle counter SHALL be $clog2(STABLE_CYCLES+1) bits wide and never wrap.
REQ-018 Skewed input transitions that do not change raw (e.g. 11->01->00) SHALL produce at most one out transition and one chg pulse.
REQ-019 Channels SHALL be fully independent; simultaneous events on all channels SHALL be handled in the same cycle.

Reset
REQ-020 rst_n low SHALL asynchronously set out to all ones, chg to zero, s1/s2 to one, FSMs to STABLE, counters and glitch_cnt to zero.
REQ-021 Reset asserted mid-SETTLING SHALL discard the pending transition; after release the channel SHALL re-evaluate from the synchronizer.

Configuration
REQ-022 With NAND_DEGLITCH_GLITCH_CNT_EN defined, glitch_cnt SHALL exist as an 8-bit per-channel counter saturating at 255.
REQ-023 Without NAND_DEGLITCH_GLITCH_CNT_EN, the glitch_cnt port and its counters SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-024 Package nand_deglitch_pkg SHALL hold the FSM state enum (STABLE, SETTLING) and constant GLITCH_CNT_W = 8.
REQ-025 Per-channel logic SHALL live in sub-module nand_deglitch_ch, instantiated CHANNELS times by a generate loop.

Verification (WIDTH=2, CHANNELS=4, STABLE_CYCLES=4, macro defined)
REQ-026 rst_n=0 with arbitrary in -> out=4'hF, chg=0, all glitch_cnt=0, asynchronously.
REQ-027 Ch0 inputs to 11 held after reset release -> out[0] falls on the 6th edge after the change, chg[0] high for exactly one following cycle.
REQ-028 Ch0 from 11, a=0 then b=0 1 ns later -> out[0] rises once, exactly one chg[0] pulse, glitch_cnt[0]=0.
REQ-029 Ch1 raw inverted for 2 cycles then restored -> out[1] unchanged, no chg, glitch_cnt[1]=1.
REQ-030 300 such 2-cycle glitches on ch2 -> glitch_cnt[2]=255, out[2] never changes.
REQ-031 rst_n pulsed low during ch3 SETTLING (count=2) -> out[3]=1 immediately, after release no transition unless raw stays changed for a full 2+4 cycles.
